// File: rtl/shifter_pkg.sv
// Shared types and stage-partitioning helpers for the pipelined barrel shifter.
// Used by shift_stage and pipe_shifter (optional flags: SHIFTER_FLAGS_EN).
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRA = 2'b01,
        SH_ROR = 2'b10,
        SH_SRL = 2'b11
    } shift_mode_e;

    // Levels handled by stage k; earlier stages absorb the remainder.
    function automatic int stage_num_levels(input int levels, input int stages, input int k);
        return (levels / stages) + ((k < (levels % stages)) ? 1 : 0);
    endfunction

    function automatic int stage_first_level(input int levels, input int stages, input int k);
        int first = 0;
        for (int i = 0; i < k; i++) begin
            first += stage_num_levels(levels, stages, i);
        end
        return first;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational group of barrel-shifter levels 2^FIRST_LEVEL .. 2^(FIRST_LEVEL+NUM_LEVELS-1).
// With SHIFTER_FLAGS_EN defined it also tracks the last bit shifted out.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FIRST_LEVEL = 0,
    parameter int NUM_LEVELS  = 1
) (
    input  logic [WIDTH-1:0]      i_data,
    input  logic [NUM_LEVELS-1:0] i_shamt,
    input  shift_mode_e           i_mode,
    input  logic                  i_sign,
`ifdef SHIFTER_FLAGS_EN
    input  logic                  i_carry,
    output logic                  o_carry,
`endif
    output logic [WIDTH-1:0]      o_data
);

    logic [WIDTH-1:0] w_lvl_data [NUM_LEVELS+1];

    assign w_lvl_data[0] = i_data;
    assign o_data        = w_lvl_data[NUM_LEVELS];

`ifdef SHIFTER_FLAGS_EN
    logic w_lvl_carry [NUM_LEVELS+1];

    assign w_lvl_carry[0] = i_carry;
    assign o_carry        = w_lvl_carry[NUM_LEVELS];
`endif

    for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_level
        localparam int AMT = 1 << (FIRST_LEVEL + l);

        logic [WIDTH-1:0] w_cur;
        logic [AMT-1:0]   w_top;
        logic [WIDTH-1:0] w_shifted;

        assign w_cur = w_lvl_data[l];

        // Bits entering from the MSB side on right shifts: wrapped bits, sign, or zero.
        always_comb begin
            w_top = '0;
            if (i_mode == SH_ROR) begin
                w_top = w_cur[AMT-1:0];
            end else if (i_mode == SH_SRA) begin
                w_top = {AMT{i_sign}};
            end
        end

        assign w_shifted = (i_mode == SH_SLL) ? {w_cur[WIDTH-AMT-1:0], {AMT{1'b0}}}
                                              : {w_top, w_cur[WIDTH-1:AMT]};
        assign w_lvl_data[l+1] = i_shamt[l] ? w_shifted : w_cur;

`ifdef SHIFTER_FLAGS_EN
        logic w_out_bit;

        assign w_out_bit = (i_mode == SH_SLL) ? w_cur[WIDTH-AMT] : w_cur[AMT-1];
        assign w_lvl_carry[l+1] = i_shamt[l] ? w_out_bit : w_lvl_carry[l];
`endif
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined SLL/SRA/ROR/SRL barrel shifter with valid/ready flow control.
// Optional zero/carry outputs are enabled by defining SHIFTER_FLAGS_EN.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH       = 16,
    parameter  int PIPE_STAGES = 2,
    localparam int SHAMT_W     = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef SHIFTER_FLAGS_EN
    output logic               out_zero,
    output logic               out_carry,
`endif
    output logic [WIDTH-1:0]   out_data
);

    localparam int LAST = PIPE_STAGES - 1;

    // Handshake: a beat moves when valid && ready on either side. The whole pipe
    // advances together whenever the output slot is empty or being consumed, so
    // in_ready depends only on out_ready and stage state, never on in_valid.
    logic w_adv;
    logic w_out_valid;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        localparam int FIRST = stage_first_level(SHAMT_W, PIPE_STAGES, k);
        localparam int NUM   = stage_num_levels(SHAMT_W, PIPE_STAGES, k);
        localparam int REM   = SHAMT_W - FIRST;

        logic [WIDTH-1:0] w_src_data;
        logic [REM-1:0]   w_src_shamt;
        shift_mode_e      w_src_mode;
        logic             w_src_sign;
        logic             w_src_valid;
        logic [WIDTH-1:0] w_res_data;
        logic [WIDTH-1:0] r_data;
        logic             r_valid;
`ifdef SHIFTER_FLAGS_EN
        logic             w_src_carry;
        logic             w_res_carry;
        logic             r_carry;
`endif

        if (k == 0) begin : g_head
            assign w_src_data  = in_data;
            assign w_src_shamt = in_shamt;
            assign w_src_mode  = shift_mode_e'(in_mode);
            assign w_src_sign  = in_data[WIDTH-1];
            assign w_src_valid = in_valid;
`ifdef SHIFTER_FLAGS_EN
            assign w_src_carry = 1'b0;
`endif
        end else begin : g_tail
            assign w_src_data  = g_stage[k-1].r_data;
            assign w_src_shamt = g_stage[k-1].g_ctl.r_shamt;
            assign w_src_mode  = g_stage[k-1].g_ctl.r_mode;
            assign w_src_sign  = g_stage[k-1].g_ctl.r_sign;
            assign w_src_valid = g_stage[k-1].r_valid;
`ifdef SHIFTER_FLAGS_EN
            assign w_src_carry = g_stage[k-1].r_carry;
`endif
        end

        shift_stage #(
            .WIDTH       (WIDTH),
            .FIRST_LEVEL (FIRST),
            .NUM_LEVELS  (NUM)
        ) u_shift_stage (
            .i_data  (w_src_data),
            .i_shamt (w_src_shamt[NUM-1:0]),
            .i_mode  (w_src_mode),
            .i_sign  (w_src_sign),
`ifdef SHIFTER_FLAGS_EN
            .i_carry (w_src_carry),
            .o_carry (w_res_carry),
`endif
            .o_data  (w_res_data)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_src_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_data <= w_res_data;
`ifdef SHIFTER_FLAGS_EN
                r_carry <= w_res_carry;
`endif
            end
        end

        // Only the still-unconsumed shamt bits, mode and sign travel onward.
        if (k < LAST) begin : g_ctl
            logic [REM-NUM-1:0] r_shamt;
            shift_mode_e        r_mode;
            logic               r_sign;

            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_shamt <= w_src_shamt[REM-1:NUM];
                    r_mode  <= w_src_mode;
                    r_sign  <= w_src_sign;
                end
            end
        end
    end

    assign w_out_valid = g_stage[LAST].r_valid;
    assign w_adv       = out_ready || !w_out_valid;
    assign in_ready    = w_adv;
    assign out_valid   = w_out_valid;
    assign out_data    = w_out_valid ? g_stage[LAST].r_data : '0;

`ifdef SHIFTER_FLAGS_EN
    assign out_zero  = w_out_valid && (g_stage[LAST].r_data == '0);
    assign out_carry = w_out_valid && g_stage[LAST].r_carry;
`endif

endmodule

// File: doc/pipe_shifter.md
Name: pipe_shifter

Overview:
Parametrised, pipelined barrel shifter. It is the next generation of the combinational 16-bit SLL/SRA/ROR shifter used by the EX stage.
- Generalises data width.
- Adds a logical right shift mode.
- Splits the log2 shift levels across configurable register stages.
- Carries a valid/ready handshake with backpressure, so it can sit in the EX stage or in a multi-cycle functional unit.

Parameters:
WIDTH, 16, data width; power of two, 4..64.
PIPE_STAGES, 2, number of register stages; 1..SHAMT_W. Shift levels are distributed evenly, earlier stages taking the extra level when the division is uneven.
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  WIDTH  operand
in_shamt  in  SHAMT_W  shift amount
in_mode  in  2  00 SLL, 01 SRA, 10 ROR, 11 SRL
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  result

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - All stage valid bits clear; out_valid=0; out_data=0.
  - in_ready=1 in the first cycle after rst deasserts.
- Transfer rules:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
- Pipeline control:
  - Global advance signal: adv = out_ready || !out_valid.
  - in_ready = adv. This is combinational from out_ready; there is no combinational path from in_valid.
  - On adv, every stage register loads from its predecessor and stage 0 loads the input beat with its valid bit.
  - When adv=0, all stages hold data, shamt, mode and valid.
  - Internal bubbles are not collapsed.
- Latency and throughput:
  - Exactly PIPE_STAGES cycles from acceptance to out_valid when there is no stall.
  - Throughput 1 beat/cycle.
  - Order is preserved.
- Stage contents:
  - Each stage carries partial data, remaining shamt bits, mode and valid.
  - Stage k applies levels 2^j for its assigned j, using only that stage's shamt bit.
- Mode semantics (shamt=s, 0 <= s <= WIDTH-1):
  - SLL: zero fill from LSB.
  - SRA: fill with original in_data[WIDTH-1]. The sign bit is captured at stage 0 and carried with the beat.
  - SRL: zero fill from MSB.
  - ROR: rotate right by s.
  - s=0 passes data unchanged in all modes.
- Invalid beats: data registers of invalid beats need not be cleared, but out_data must read 0 whenever out_valid=0 (output register gated).
- Reset mid-operation: all in-flight beats are discarded with no output; no partial result appears.
- Simultaneous events:
  - A full pipeline with out_ready=1 accepts and emits in the same cycle.
  - rst has priority over every handshake.

Optional Feature:
Macro SHIFTER_FLAGS_EN.
- Defined: adds outputs out_zero (1 = out_data==0) and out_carry (last bit shifted out), both aligned with out_data and reset to 0.
- out_carry definition:
  - SLL: in_data[WIDTH-s].
  - SRA/SRL: in_data[s-1].
  - ROR: out_data[WIDTH-1].
  - s=0: 0.
- Carry is tracked per stage through the pipeline.
- Undefined: these ports and their logic are absent; nothing else changes.

Decomposition:
- Package shifter_pkg holds:
  - Mode enum: SH_SLL=2'b00, SH_SRA=2'b01, SH_ROR=2'b10, SH_SRL=2'b11.
  - Function computing levels-per-stage from WIDTH and PIPE_STAGES.
- Sub-module shift_stage: combinational group of log levels for one stage. Parameters are WIDTH, FIRST_LEVEL and NUM_LEVELS; it carries the carry bit when flags are enabled.
- pipe_shifter instantiates PIPE_STAGES of these with the stage registers and handshake.

Test Plan:
- WIDTH=16, PIPE_STAGES=2, out_ready=1. Input SLL 0x8001 shamt 1 -> out_data 0x0002 exactly 2 cycles after accept.
- SRA 0x8000 shamt 15 -> 0xFFFF. SRL 0x8000 shamt 15 -> 0x0001. SRA 0x4000 shamt 14 -> 0x0001.
- ROR 0x1234 shamt 4 -> 0x4123. ROR 0x1234 shamt 0 -> 0x1234. Back-to-back beats every cycle yield results every cycle in order.
- Backpressure: send beats A, B, C with out_ready=0.
  - out_valid holds A stable.
  - in_ready drops once the pipeline is full (both stages plus output valid).
  - Raising out_ready drains A, B, C in order with no loss or duplication.
- Assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0, out_data=0. No stale beat emerges afterward.
- SHIFTER_FLAGS_EN defined:
  - SLL 0x8000 shamt 1 -> out_data 0x0000, carry=1, zero=1.
  - SRL 0x0003 shamt 1 -> 0x0001, carry=1, zero=0.
  - Repeat random sweep at WIDTH=32, PIPE_STAGES=5 against a behavioural model.
